// File: rtl/sram_uart_dump_pkg.sv
// Shared types and constants for the SRAM-to-UART dump block: FSM states and the PPM header ROM.
package sram_uart_dump_pkg;

    typedef enum logic [2:0] {
        S_DUMP_IDLE,
        S_HEADER,
        S_READ_ADDR,
        S_READ_WAIT1,
        S_READ_WAIT2,
        S_TX_HI,
        S_TX_LO,
        S_DUMP_DONE
    } dump_state_type;

    localparam int unsigned PPM_HEADER_LEN = 15;

    // "P6\n320 240\n255\n"
    localparam logic [7:0] PPM_HEADER [PPM_HEADER_LEN] = '{
        8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
        8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A
    };

    function automatic logic [7:0] header_byte(input logic [3:0] idx);
        return (idx < 4'(PPM_HEADER_LEN)) ? PPM_HEADER[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer: accepts a byte when idle and shifts out start, 8 data (LSB first), stop.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Tx_start,
    input  logic [7:0] Tx_byte,
    output logic       Tx_busy,
    output logic       UART_TX_O
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic          busy_q, busy_d;

    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        if (!busy_q) begin
            if (Tx_start) begin
                busy_d  = 1'b1;
                baud_d  = '0;
                bit_d   = 4'd0;
                shift_d = {1'b1, Tx_byte, 1'b0};
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_d  = '0;
            // Ones shift in behind the frame, so the line rests high once the stop bit ends.
            shift_d = {1'b1, shift_q[9:1]};
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                bit_d  = 4'd0;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            baud_d = baud_q + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= '1;
            busy_q  <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
        end
    end

    assign Tx_busy   = busy_q;
    assign UART_TX_O = shift_q[0];

endmodule

// File: rtl/sram_uart_dump.sv
// Streams a region of 16-bit SRAM out over UART (high byte first), optionally after a PPM header.
module sram_uart_dump
    import sram_uart_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned DEFAULT_WORDS = 115200,
    parameter int unsigned SEND_HEADER   = 1
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start_i,
    input  logic [17:0] Base_address_i,
    input  logic [17:0] Word_count_i,
    input  logic [15:0] SRAM_read_data_i,
    output logic [17:0] SRAM_address_o,
    output logic        SRAM_we_n_o,
    output logic        UART_TX_O,
    output logic        Busy_o,
    output logic        Done_o
);

    dump_state_type state_q, state_d;
    logic [17:0]    addr_q, addr_d;
    logic [17:0]    sram_addr_q, sram_addr_d;
    logic [17:0]    cnt_q, cnt_d;
    logic [15:0]    word_q, word_d;
    logic [3:0]     hdr_idx_q, hdr_idx_d;
    logic           tx_start, tx_busy;
    logic [7:0]     tx_byte;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sram_addr_d = sram_addr_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        hdr_idx_d   = hdr_idx_q;
        tx_start    = 1'b0;
        tx_byte     = 8'h00;
        Done_o      = 1'b0;
        unique case (state_q)
            S_DUMP_IDLE: begin
                if (Start_i) begin
                    addr_d    = Base_address_i;
                    cnt_d     = (Word_count_i == '0) ? 18'(DEFAULT_WORDS) : Word_count_i;
                    hdr_idx_d = 4'd0;
                    state_d   = (SEND_HEADER != 0) ? S_HEADER : S_READ_ADDR;
                end
            end
            S_HEADER: begin
                tx_start = 1'b1;
                tx_byte  = header_byte(hdr_idx_q);
                if (!tx_busy) begin
                    if (hdr_idx_q == 4'(PPM_HEADER_LEN - 1)) begin
                        state_d = S_READ_ADDR;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end
                end
            end
            S_READ_ADDR: begin
                sram_addr_d = addr_q;
                state_d     = S_READ_WAIT1;
            end
            S_READ_WAIT1: state_d = S_READ_WAIT2;
            S_READ_WAIT2: begin
                word_d  = SRAM_read_data_i;
                state_d = S_TX_HI;
            end
            S_TX_HI: begin
                tx_start = 1'b1;
                tx_byte  = word_q[15:8];
                if (!tx_busy) begin
                    state_d = S_TX_LO;
                end
            end
            S_TX_LO: begin
                tx_start = 1'b1;
                tx_byte  = word_q[7:0];
                if (!tx_busy) begin
                    addr_d  = addr_q + 18'd1;
                    cnt_d   = cnt_q - 18'd1;
                    // The next word is fetched while this low byte is still on the wire.
                    state_d = (cnt_q == 18'd1) ? S_DUMP_DONE : S_READ_ADDR;
                end
            end
            S_DUMP_DONE: begin
                // Hold off until the final stop bit has fully left the serializer.
                if (!tx_busy) begin
                    Done_o  = 1'b1;
                    state_d = S_DUMP_IDLE;
                end
            end
            default: state_d = S_DUMP_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_DUMP_IDLE;
            addr_q      <= '0;
            sram_addr_q <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            hdr_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sram_addr_q <= sram_addr_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            hdr_idx_q   <= hdr_idx_d;
        end
    end

    assign SRAM_address_o = (state_q == S_READ_ADDR) ? addr_q : sram_addr_q;
    assign SRAM_we_n_o    = 1'b1;
    assign Busy_o         = (state_q != S_DUMP_IDLE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Tx_start (tx_start),
        .Tx_byte  (tx_byte),
        .Tx_busy  (tx_busy),
        .UART_TX_O(UART_TX_O)
    );

endmodule

// File: tb/tb_sram_uart_dump.sv
// Bench for sram_uart_dump: three parameterisations, per-instance SRAM model and UART line decoder.
module tb_sram_uart_dump;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Resetn;
    logic [2:0]  start;
    logic [17:0] base, wcount;
    logic [17:0] addr [3];
    logic [2:0]  we_n, tx, busy, done;

    logic [15:0] mem [0:262143];
    logic [7:0]  exp_q [3][$];
    logic [7:0]  hdr [15] = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
                              8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};
    int          cyc;
    int          checks, errors;
    int          dump_id [3];
    int          done_cnt [3];
    int          we_low;
    logic [17:0] addr_log [$];
    logic [17:0] last_addr0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        for (int k = 0; k < 3; k++) if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        if (Resetn && we_n !== 3'b111) we_low <= we_low + 1;
        if (addr[0] !== last_addr0) addr_log.push_back(addr[0]);
        last_addr0 <= addr[0];
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CPB = (g == 2) ? 2 : 4;
        logic [15:0] d1, rd;

        sram_uart_dump #(
            .CLKS_PER_BIT (CPB),
            .DEFAULT_WORDS((g == 2) ? 3 : 115200),
            .SEND_HEADER  ((g == 1) ? 1 : 0)
        ) u_dut (
            .Clock           (Clock),
            .Resetn          (Resetn),
            .Start_i         (start[g]),
            .Base_address_i  (base),
            .Word_count_i    (wcount),
            .SRAM_read_data_i(rd),
            .SRAM_address_o  (addr[g]),
            .SRAM_we_n_o     (we_n[g]),
            .UART_TX_O       (tx[g]),
            .Busy_o          (busy[g]),
            .Done_o          (done[g])
        );

        // Read data is valid two clocks after the address.
        always @(posedge Clock) begin
            d1 <= mem[addr[g]];
            rd <= d1;
        end

        initial begin : dec
            logic [7:0] data;
            bit         ok, abort;
            int         t0, prev_t, prev_id;
            prev_id = -1;
            prev_t  = 0;
            forever begin
                @(negedge Clock);
                if (Resetn && tx[g] === 1'b0) begin
                    t0    = cyc;
                    ok    = 1'b1;
                    abort = 1'b0;
                    data  = 8'h00;
                    for (int b = 0; b < 10; b++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (b != 0 || c != 0) @(negedge Clock);
                            if (!Resetn) abort = 1'b1;
                            if (b == 0) begin
                                if (tx[g] !== 1'b0) ok = 1'b0;
                            end else if (b == 9) begin
                                if (tx[g] !== 1'b1) ok = 1'b0;
                            end else if (c == 0) begin
                                data[b-1] = tx[g];
                            end else if (tx[g] !== data[b-1]) begin
                                ok = 1'b0;
                            end
                        end
                    end
                    if (!abort) begin
                        check("frame bit timing", ok, 1);
                        check("byte expected", exp_q[g].size() > 0, 1);
                        if (exp_q[g].size() > 0) check("byte value", data, exp_q[g].pop_front());
                        if (dump_id[g] == prev_id)
                            check("start spacing ok", (t0 - prev_t) <= 10 * CPB + 4, 1);
                        prev_t  = t0;
                        prev_id = dump_id[g];
                    end
                end
            end
        end
    end

    task automatic pulse_start(input int g, input logic [17:0] b, input logic [17:0] c,
                               input bit new_dump);
        base   = b;
        wcount = c;
        if (new_dump) dump_id[g]++;
        start[g] = 1'b1;
        @(negedge Clock);
        start[g] = 1'b0;
    endtask

    task automatic push_expected(input int g, input logic [17:0] b, input int words);
        logic [17:0] a;
        if (g == 1) for (int k = 0; k < 15; k++) exp_q[g].push_back(hdr[k]);
        for (int w = 0; w < words; w++) begin
            a = b + 18'(w);
            exp_q[g].push_back(mem[a][15:8]);
            exp_q[g].push_back(mem[a][7:0]);
        end
    endtask

    task automatic wait_done(input int g, input int budget, output bit seen, output int busy_low);
        seen     = 1'b0;
        busy_low = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge Clock);
            if (done[g]) seen = 1'b1;
            else if (!busy[g]) busy_low++;
        end
    endtask

    typedef struct {
        int          g;
        logic [17:0] base;
        logic [17:0] count;
        int          words;
        logic [15:0] mem0;
        bit          poke;
        bit          start_at_done;
        bit          chk_addr;
    } vec_t;

    initial begin
        vec_t vecs [5];
        vec_t v;
        bit   seen;
        int   busy_low, done_before;

        vecs[0] = '{0, 18'd100,    18'd2, 2, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1, 18'd0,      18'd1, 1, 16'h1234, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{0, 18'd262143, 18'd2, 2, 16'hCAFE, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{2, 18'd200,    18'd0, 3, 16'hCAFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2, 18'd7,      18'd1, 1, 16'hCAFE, 1'b0, 1'b0, 1'b0};
        mem[100]    = 16'hA55A;
        mem[101]    = 16'h0180;
        mem[262143] = 16'hBEEF;
        mem[200]    = 16'h1111;
        mem[201]    = 16'h2233;
        mem[202]    = 16'h4455;
        mem[203]    = 16'h6677;
        mem[7]      = 16'h9A0F;

        Resetn = 1'b0;
        start  = 3'b000;
        base   = '0;
        wcount = '0;
        repeat (3) @(negedge Clock);
        check("reset tx", tx, 3'b111);
        check("reset we_n", we_n, 3'b111);
        check("reset busy", busy, 3'b000);
        check("reset done", done, 3'b000);
        check("reset addr", addr[0], 0);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);

        for (int i = 0; i < 5; i++) begin
            v           = vecs[i];
            mem[0]      = v.mem0;
            done_before = done_cnt[v.g];
            addr_log.delete();
            push_expected(v.g, v.base, v.words);
            pulse_start(v.g, v.base, v.count, 1'b1);
            if (v.poke) begin
                repeat (10) @(negedge Clock);
                pulse_start(v.g, 18'd5, 18'd7, 1'b0);
            end
            wait_done(v.g, (2 * v.words + 15) * 40 + 100, seen, busy_low);
            check("done seen", seen, 1);
            check("bytes outstanding at done", exp_q[v.g].size(), 0);
            check("busy dropped during dump", busy_low, 0);
            if (v.start_at_done) start[v.g] = 1'b1;
            @(negedge Clock);
            start[v.g] = 1'b0;
            repeat (4) @(negedge Clock);
            check("busy after done", busy[v.g], 0);
            check("done pulse count", done_cnt[v.g] - done_before, 1);
            if (v.chk_addr) begin
                check("addr log length", addr_log.size(), 2);
                if (addr_log.size() == 2) begin
                    check("addr first", addr_log[0], 262143);
                    check("addr wrapped", addr_log[1], 0);
                end
            end
            exp_q[v.g].delete();
            repeat (20) @(negedge Clock);
        end

        // Reset in the middle of data bit 3 of the first header byte.
        done_before = done_cnt[1];
        pulse_start(1, 18'd0, 18'd1, 1'b1);
        repeat (6) @(negedge Clock);
        pulse_start(1, 18'd50, 18'd9, 1'b0);
        repeat (11) @(negedge Clock);
        check("line low before reset", tx[1], 0);
        Resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("tx high in reset", tx[1], 1);
            check("busy low in reset", busy[1], 0);
            check("done low in reset", done[1], 0);
            @(negedge Clock);
        end
        Resetn = 1'b1;
        repeat (60) @(negedge Clock);
        check("no done after reset", done_cnt[1] - done_before, 0);
        check("idle after reset", busy[1], 0);
        exp_q[1].delete();
        mem[0] = 16'h1234;
        push_expected(1, 18'd0, 1);
        pulse_start(1, 18'd0, 18'd1, 1'b1);
        wait_done(1, 17 * 40 + 100, seen, busy_low);
        check("restart done seen", seen, 1);
        check("restart bytes outstanding", exp_q[1].size(), 0);
        repeat (5) @(negedge Clock);
        check("restart done count", done_cnt[1] - done_before, 1);
        check("we_n never low", we_low, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
